// File: rtl/rotate_sequencer_if.sv
// Request/result bundle for rotate_sequencer: two requester ports plus the result port.
// The slave modport is the sequencer's side; the master modport is its environment's side.
interface rotate_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [AMT_W-1:0] req0_amt;
    logic             req0_dir;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [AMT_W-1:0] req1_amt;
    logic             req1_dir;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_id;

    modport master (
        output req0_valid, req0_a, req0_amt, req0_dir,
        output req1_valid, req1_a, req1_amt, req1_dir,
        output out_ready,
        input  req0_ready, req1_ready, out_valid, out_y, out_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_amt, req0_dir,
        input  req1_valid, req1_a, req1_amt, req1_dir,
        input  out_ready,
        output req0_ready, req1_ready, out_valid, out_y, out_id
    );
endinterface

// File: rtl/rotate_sequencer.sv
// Round-robin scheduler for two requesters feeding a single-step rotator.
// Each accepted op is rotated one position per clock until its amount is used up.
module rotate_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    rotate_sequencer_if.slave   bus,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [AMT_W-1:0] cnt_reg, cnt_next;
    logic             dir_reg, dir_next;
    logic             id_reg, id_next;
    logic             last_grant_reg, last_grant_next;

    logic             grant0, grant1;
    logic [WIDTH-1:0] rot_l, rot_r, rot_step;

    // Single-step rotator: a plain per-bit mux on direction.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rot_l[gi] = work_reg[(gi + WIDTH - 1) % WIDTH];
            assign rot_r[gi] = work_reg[(gi + 1) % WIDTH];
        end
    endgenerate

    assign rot_step = dir_reg ? rot_r : rot_l;

    // Grant favours the requester that was not served last when both are asking.
    assign grant0 = (state_reg == IDLE) && bus.req0_valid && (!bus.req1_valid || last_grant_reg);
    assign grant1 = (state_reg == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_grant_reg);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.out_valid  = (state_reg == DONE);
    assign bus.out_y      = work_reg;
    assign bus.out_id     = id_reg;
    assign busy           = (state_reg != IDLE);

    always_comb begin
        state_next      = state_reg;
        work_next       = work_reg;
        cnt_next        = cnt_reg;
        dir_next        = dir_reg;
        id_next         = id_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (grant0) begin
                    work_next       = bus.req0_a;
                    cnt_next        = bus.req0_amt;
                    dir_next        = bus.req0_dir;
                    id_next         = 1'b0;
                    last_grant_next = 1'b0;
                    state_next      = (bus.req0_amt == '0) ? DONE : RUN;
                end else if (grant1) begin
                    work_next       = bus.req1_a;
                    cnt_next        = bus.req1_amt;
                    dir_next        = bus.req1_dir;
                    id_next         = 1'b1;
                    last_grant_next = 1'b1;
                    state_next      = (bus.req1_amt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                work_next = rot_step;
                cnt_next  = cnt_reg - AMT_W'(1);
                if (cnt_reg == AMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Result holds until taken; no same-cycle hand-off to a new grant.
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            work_reg       <= '0;
            cnt_reg        <= '0;
            dir_reg        <= 1'b0;
            id_reg         <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            work_reg       <= work_next;
            cnt_reg        <= cnt_next;
            dir_reg        <= dir_next;
            id_reg         <= id_next;
            last_grant_reg <= last_grant_next;
        end
    end
endmodule
